mc_seq_ctrl: RTL

//  Multi-cycle sequencer for the LoongArch mycpu core: owns the PC, IR and state register.

---
 rtl/mc_seq_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multi-cycle IF/ID/EXE/MEM/WB sequencer owning PC, IR and state register.
// Performance counters are built only when MC_PERF_CNT_EN is defined.
module mc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  input  logic        dec_is_br,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_gr_we,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        opnd_le,
  output logic        alu_le,
  output logic        data_req,
  output logic        data_we,
  input  logic        data_ack,
  output logic        rf_we,
  output logic        retire,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        run_q;
  logic        retire_c;
  logic        is_load;
  logic        is_store;

  // Load wins when the decoder flags both load and store.
  assign is_load  = dec_is_load;
  assign is_store = dec_is_store & ~dec_is_load;

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    retire_c = 1'b0;
    case (state_q)
      S_IF: begin
        if (run_q && inst_ack) begin
          ir_d    = inst_rdata;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (dec_is_br) begin
          retire_c = 1'b1;
          state_d  = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (dec_gr_we) begin
          state_d = S_WB;
        end else begin
          retire_c = 1'b1;
          state_d  = S_IF;
        end
      end
      S_MEM: begin
        if (data_ack) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            retire_c = 1'b1;
            state_d  = S_IF;
          end
        end
      end
      S_WB: begin
        retire_c = 1'b1;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  assign pc_d = retire_c ? (br_taken ? br_target : pc_q + 32'd4) : pc_q;

  // run_q keeps the fetch request low until the first edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IF;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      run_q   <= 1'b1;
    end
  end

  assign inst_req = run_q && (state_q == S_IF);
  assign opnd_le  = (state_q == S_ID);
  assign alu_le   = (state_q == S_EXE);
  assign data_req = (state_q == S_MEM);
  assign data_we  = (state_q == S_MEM) && is_store;
  assign rf_we    = (state_q == S_WB) && dec_gr_we;
  assign retire   = retire_c;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign state    = state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instret_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_cnt_q   <= 32'h0;
      instret_cnt_q <= 32'h0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (retire_c) begin
        instret_cnt_q <= instret_cnt_q + 32'd1;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = 32'h0;
  assign instret_cnt = 32'h0;
`endif

endmodule
